fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 4: number of requesters; legal range 2..16.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, NUM_REQ: bit i set means requester i presents a word.
REQ-006 SHALL have port req_data, input, NUM_REQ*WIDTH: requester i word in bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port req_last, input, NUM_REQ: bit i marks the presented word as the final word of a packet.
REQ-008 SHALL have port req_ready, output, NUM_REQ: bit i means requester i's word is accepted this cycle.
REQ-009 SHALL have port fifo_din, output, WIDTH: data driven to the shared FIFO write port.
REQ-010 SHALL have port fifo_wr_en, output, 1: FIFO write strobe.
REQ-011 SHALL have port fifo_full, input, 1: FIFO full flag.
REQ-012 SHALL have port grant, output, NUM_REQ: one-hot selected requester, or all-zero when none is selected.
REQ-013 SHALL have port locked, output, 1: high while a multi-word packet owns the FIFO.

Function
REQ-014 SHALL define transfer(i) as req_valid[i] && req_ready[i] on a rising clk edge; at most one transfer per cycle.
REQ-015 SHALL implement state machine IDLE/LOCKED with registered state, owner index and round-robin pointer rr_ptr.
REQ-016 In IDLE, grant SHALL combinationally select the first requester with req_valid set, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
REQ-017 In LOCKED, grant SHALL be one-hot on owner regardless of other req_valid bits, and all-zero if req_valid[owner] is low.
REQ-018 req_ready[i] SHALL equal grant[i] && !fifo_full; every other ready bit SHALL be 0.
REQ-019 fifo_wr_en SHALL equal the OR of (req_valid & req_ready); fifo_din SHALL equal the data of the granted requester, or 0 when grant is all-zero.
REQ-020 Latency: the accepted word SHALL appear on fifo_din/fifo_wr_en in the same cycle with no added register stage.
REQ-021 Transfer with req_last=0 in IDLE SHALL move the block to LOCKED with owner set to that requester; rr_ptr stays unchanged.
REQ-022 Transfer with req_last=1 in either state SHALL move the block to IDLE and set rr_ptr to (granted index + 1) mod NUM_REQ.
REQ-023 Transfer with req_last=0 in LOCKED SHALL leave state, owner and rr_ptr unchanged.
REQ-024 fifo_full high SHALL stall all transfers; state, owner and rr_ptr SHALL hold; grant SHALL still be driven per REQ-016/017.
REQ-025 A requester that deasserts req_valid while locked SHALL keep ownership; the arbiter SHALL insert bubbles and never switch owners mid-packet.
REQ-026 rr_ptr wrap-around SHALL be modulo NUM_REQ, including non-power-of-two values.
REQ-027 locked SHALL be 1 exactly when state is LOCKED.

Reset
REQ-028 rst_n low SHALL immediately and asynchronously force state=IDLE, owner=0, rr_ptr=0 and locked=0, regardless of clk.
REQ-029 During reset, req_ready, grant and fifo_wr_en SHALL be 0, and fifo_din SHALL be 0.
REQ-030 Reset asserted mid-packet SHALL abandon the packet; after release, arbitration SHALL restart from requester 0.
REQ-031 Reset release SHALL be synchronized externally; the first transfer after release SHALL be possible on the first clk edge.

Verification
REQ-032 Round-robin check: after reset, hold req_valid=4'b1111 and req_last=4'b1111, fifo_full=0 -> grants on successive cycles are 0,1,2,3,0; fifo_wr_en=1 on every cycle.
REQ-033 Packet lock check: req0 sends a 3-word packet (last on word 3) while req1 stays valid -> grant stays 4'b0001 for 3 transfers and locked=1 after word 1; req1 is granted on the next cycle.
REQ-034 Full stall check: raise fifo_full for 5 cycles mid-packet -> req_ready=0 and fifo_wr_en=0 for those cycles; no owner change; the packet resumes with the next word.
REQ-035 Bubble check: the owner drops req_valid for 2 cycles while locked and req2 is valid -> grant=0, fifo_wr_en=0, req_ready[2]=0; the owner continues afterward.
REQ-036 Async reset check: assert rst_n=0 between clock edges while locked -> locked, grant and req_ready go to 0 before the next edge; after release with all valid, grant=4'b0001.
REQ-037 NUM_REQ=3 wrap check: all valid with last=1 -> grant sequence 0,1,2,0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that lets NUM_REQ requesters share a single FIFO write
// port, with packet locking so that a multi-word packet is never interleaved with other traffic.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   req_valid  - per-requester word-present flags
//   req_data   - per-requester words, requester i in bits [i*WIDTH +: WIDTH]
//   req_last   - per-requester end-of-packet flags for the presented word
//   req_ready  - per-requester accept flags (at most one set)
//   fifo_din   - word driven to the FIFO write port (0 when nothing is granted)
//   fifo_wr_en - FIFO write strobe
//   fifo_full  - FIFO full flag; stalls every transfer while high
//   grant      - one-hot selected requester, all-zero when none is selected
//   locked     - high while a multi-word packet owns the FIFO
//
// The data path is purely combinational: an accepted word reaches fifo_din/fifo_wr_en in the
// same cycle it is presented. Only the arbitration state (state, owner, rr pointer) is
// registered.

module fifo_wr_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         fifo_din,
  output logic                     fifo_wr_en,
  input  logic                     fifo_full,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     locked
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef logic [IdxW-1:0] idx_t;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } state_e;

  state_e      state_q;
  idx_t        owner_q;
  idx_t        rr_ptr_q;
  logic        locked_q;

  idx_t        sel_idx;
  logic        sel_any;
  logic        sel_last;
  logic        xfer;
  idx_t        next_ptr;
  int unsigned cand;

  // ---------------------------------------------------------------------------------------------
  // Requester selection
  // ---------------------------------------------------------------------------------------------
  // In IDLE, scan from rr_ptr upward (modulo NUM_REQ) and take the first valid requester.
  // In LOCKED, only the owner may be selected; if it has nothing to offer this cycle the
  // arbiter emits a bubble rather than letting anyone else in mid-packet.
  always_comb begin
    sel_idx = '0;
    sel_any = 1'b0;
    cand    = 0;
    if (state_q == StLocked) begin
      sel_idx = owner_q;
      sel_any = req_valid[owner_q];
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = (32'(rr_ptr_q) + k) % NUM_REQ;
        if (!sel_any && req_valid[idx_t'(cand)]) begin
          sel_any = 1'b1;
          sel_idx = idx_t'(cand);
        end
      end
    end
    // Outputs must read as idle while reset is held, independent of the clock.
    if (!rst_n) begin
      sel_any = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Grant decode and write-port mux
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    grant    = '0;
    fifo_din = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_any && (sel_idx == idx_t'(i))) begin
        grant[i] = 1'b1;
        fifo_din = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign req_ready  = grant & {NUM_REQ{~fifo_full}};
  assign fifo_wr_en = |(req_valid & req_ready);
  assign locked     = locked_q;

  // Only the granted requester can be ready, so a write strobe is exactly one transfer.
  assign xfer     = fifo_wr_en;
  assign sel_last = req_last[sel_idx];

  // Explicit wrap keeps the pointer legal for non-power-of-two NUM_REQ.
  assign next_ptr = (sel_idx == idx_t'(NUM_REQ - 1)) ? '0 : sel_idx + idx_t'(1);

  // ---------------------------------------------------------------------------------------------
  // Arbitration state machine
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      locked_q <= 1'b0;
    end else if (xfer) begin
      if (sel_last) begin
        // End of packet (or single-word packet): release and move fairness past the winner.
        state_q  <= StIdle;
        locked_q <= 1'b0;
        rr_ptr_q <= next_ptr;
      end else if (state_q == StIdle) begin
        // First word of a multi-word packet: the winner keeps the port until its last word.
        state_q  <= StLocked;
        locked_q <= 1'b1;
        owner_q  <= sel_idx;
      end
      // Non-last word while locked: nothing changes.
    end
  end

`ifndef SYNTHESIS
  // Sanity properties on the arbitration state.
  grant_onehot0_a : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));

  locked_matches_state_a : assert property (
    @(posedge clk) disable iff (!rst_n) locked == (state_q == StLocked)
  );

  owner_stable_a : assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == StLocked && !(xfer && sel_last)) |=> (owner_q == $past(owner_q))
  );

  ready_needs_room_a : assert property (
    @(posedge clk) disable iff (!rst_n) fifo_full |-> (req_ready == '0)
  );
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios for round robin, packet locking,
// full stalls, bubbles, async reset and NUM_REQ=3 wrap, followed by randomized traffic checked
// against a transaction-level model (owner-or-none plus a fairness pointer).

module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   fifo_din;
  logic           fifo_wr_en;
  logic           fifo_full;
  logic [N-1:0]   grant;
  logic           locked;

  // NUM_REQ = 3 instance for the wrap check.
  logic [2:0]     v3;
  logic [3*W-1:0] d3;
  logic [2:0]     l3;
  logic [2:0]     rdy3;
  logic [W-1:0]   din3;
  logic           wr3;
  logic           full3;
  logic [2:0]     g3;
  logic           lk3;

  int n_checks;
  int n_fail;

  // Reference model: -1 means no packet owns the port.
  int m_owner;
  int m_rr;

  fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .fifo_full  (fifo_full),
    .grant      (grant),
    .locked     (locked)
  );

  fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(3)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (v3),
    .req_data   (d3),
    .req_last   (l3),
    .req_ready  (rdy3),
    .fifo_din   (din3),
    .fifo_wr_en (wr3),
    .fifo_full  (full3),
    .grant      (g3),
    .locked     (lk3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_sel(logic [N-1:0] v);
    if (m_owner >= 0) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_rr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int g);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [W-1:0] word_of(int g);
    logic [N*W-1:0] d;
    d = req_data;
    if (g < 0) return '0;
    return d[g*W +: W];
  endfunction

  // Update the model from the inputs about to be sampled, then cross the clock edge.
  task automatic advance();
    int g;
    g = model_sel(req_valid);
    if (rst_n && g >= 0 && !fifo_full) begin
      if (req_last[g]) begin
        m_owner = -1;
        m_rr    = (g + 1) % N;
      end else if (m_owner < 0) begin
        m_owner = g;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    req_last  = '1;
    req_data  = 32'hA1B2C3D4;
    fifo_full = 1'b0;
    v3 = '0; d3 = '0; l3 = '0; full3 = 1'b0;
    m_owner = -1;
    m_rr    = 0;
    #2;
    n_checks++;
    if (grant !== '0) begin
      n_fail++; $display("FAIL reset_grant: got %b want 0000", grant);
    end
    n_checks++;
    if (req_ready !== '0 || fifo_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: ready %b wr_en %b want 0/0", req_ready, fifo_wr_en);
    end
    n_checks++;
    if (fifo_din !== '0 || locked !== 1'b0) begin
      n_fail++; $display("FAIL reset_din_locked: din %h locked %b want 00/0", fifo_din, locked);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    fifo_full = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req_data = $urandom;
      @(negedge clk);
      n_checks++;
      if (grant !== onehot(exp_seq[c]) || fifo_wr_en !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_grant c%0d: grant %b wr_en %b want %b/1", c, grant, fifo_wr_en,
                 onehot(exp_seq[c]));
      end
      n_checks++;
      if (fifo_din !== word_of(exp_seq[c])) begin
        n_fail++; $display("FAIL rr_din c%0d: got %h want %h", c, fifo_din, word_of(exp_seq[c]));
      end
      advance();
    end
  endtask

  task automatic test_packet_lock();
    // Single word from req3 parks the pointer at 0.
    req_valid = 4'b1000;
    req_last  = 4'b1000;
    @(negedge clk);
    advance();
    req_valid = 4'b0011;
    for (int w = 0; w < 3; w++) begin
      req_data = $urandom;
      req_last = (w == 2) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      n_checks++;
      if (grant !== 4'b0001 || req_ready !== 4'b0001) begin
        n_fail++; $display("FAIL lock_grant w%0d: grant %b ready %b want 0001", w, grant, req_ready);
      end
      n_checks++;
      if (locked !== (w != 0)) begin
        n_fail++; $display("FAIL lock_flag w%0d: got %b want %b", w, locked, (w != 0));
      end
      advance();
    end
    req_last = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0010 || locked !== 1'b0) begin
      n_fail++; $display("FAIL lock_release: grant %b locked %b want 0010/0", grant, locked);
    end
    advance();
  endtask

  task automatic test_full_stall();
    logic [W-1:0] w2;
    req_valid = 4'b0110;
    req_last  = 4'b0000;
    req_data  = $urandom;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0100 || fifo_wr_en !== 1'b1) begin
      n_fail++; $display("FAIL stall_start: grant %b wr_en %b want 0100/1", grant, fifo_wr_en);
    end
    advance();
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== '0 || fifo_wr_en !== 1'b0 || grant !== 4'b0100 || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold c%0d: ready %b wr_en %b grant %b locked %b want 0000/0/0100/1",
                 c, req_ready, fifo_wr_en, grant, locked);
      end
      advance();
    end
    fifo_full = 1'b0;
    req_data  = $urandom;
    w2        = req_data[2*W +: W];
    @(negedge clk);
    n_checks++;
    if (fifo_wr_en !== 1'b1 || req_ready !== 4'b0100 || fifo_din !== w2) begin
      n_fail++;
      $display("FAIL stall_resume: wr_en %b ready %b din %h want 1/0100/%h", fifo_wr_en,
               req_ready, fifo_din, w2);
    end
    advance();
    req_last = 4'b0100;
    @(negedge clk);
    advance();
  endtask

  task automatic test_bubble();
    req_valid = 4'b1000;
    req_last  = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b1000) begin
      n_fail++; $display("FAIL bubble_start: grant %b want 1000", grant);
    end
    advance();
    req_valid = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (grant !== '0 || fifo_wr_en !== 1'b0 || req_ready[2] !== 1'b0 || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL bubble_hold c%0d: grant %b wr_en %b ready %b locked %b want 0/0/0/1",
                 c, grant, fifo_wr_en, req_ready, locked);
      end
      advance();
    end
    req_valid = 4'b1100;
    req_last  = 4'b1000;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b1000 || fifo_wr_en !== 1'b1) begin
      n_fail++; $display("FAIL bubble_resume: grant %b wr_en %b want 1000/1", grant, fifo_wr_en);
    end
    advance();
  endtask

  task automatic test_async_reset();
    req_valid = 4'b0001;
    req_last  = 4'b0000;
    @(negedge clk);
    advance();
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL areset_prelock: locked %b want 1", locked);
    end
    #3;
    rst_n = 1'b0;
    m_owner = -1;
    m_rr    = 0;
    #1;
    n_checks++;
    if (locked !== 1'b0 || grant !== '0 || req_ready !== '0 || fifo_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_async: locked %b grant %b ready %b wr_en %b want all 0", locked,
               grant, req_ready, fifo_wr_en);
    end
    #1;
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    #1;
    n_checks++;
    if (grant !== 4'b0001) begin
      n_fail++; $display("FAIL areset_restart: grant %b want 0001", grant);
    end
    advance();
  endtask

  task automatic test_wrap3();
    int exp_seq [4] = '{0, 1, 2, 0};
    logic [2:0] want;
    req_valid = '0;
    v3 = 3'b111;
    l3 = 3'b111;
    for (int c = 0; c < 4; c++) begin
      d3 = 24'($urandom);
      @(negedge clk);
      want = 3'b001 << exp_seq[c];
      n_checks++;
      if (g3 !== want || wr3 !== 1'b1) begin
        n_fail++; $display("FAIL wrap3 c%0d: grant %b wr_en %b want %b/1", c, g3, wr3, want);
      end
      advance();
    end
    v3 = '0;
  endtask

  task automatic test_random();
    int g;
    logic [N-1:0] eg;
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom);
      req_last  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      req_data  = $urandom;
      fifo_full = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      g  = model_sel(req_valid);
      eg = onehot(g);
      n_checks++;
      if (grant !== eg) begin
        n_fail++; $display("FAIL rand_grant c%0d: got %b want %b", c, grant, eg);
      end
      n_checks++;
      if (req_ready !== (fifo_full ? 4'b0000 : eg)) begin
        n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", c, req_ready,
                           (fifo_full ? 4'b0000 : eg));
      end
      n_checks++;
      if (fifo_wr_en !== (g >= 0 && !fifo_full)) begin
        n_fail++; $display("FAIL rand_wr_en c%0d: got %b want %b", c, fifo_wr_en,
                           (g >= 0 && !fifo_full));
      end
      n_checks++;
      if (fifo_din !== word_of(g)) begin
        n_fail++; $display("FAIL rand_din c%0d: got %h want %h", c, fifo_din, word_of(g));
      end
      n_checks++;
      if (locked !== (m_owner >= 0)) begin
        n_fail++; $display("FAIL rand_locked c%0d: got %b want %b", c, locked, (m_owner >= 0));
      end
      advance();
    end
    fifo_full = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_full_stall();
    test_bubble();
    test_async_reset();
    test_wrap3();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
